// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the default baud divider.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 417;
  localparam int unsigned UART_STATE_W              = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready byte-stream handshake between a producer and the UART transmitter.
interface uart_tx_stream_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared between the UART transmitter and receiver.
module uart_baud_tick #(
  parameter  int unsigned CLKS_PER_BIT = 417,
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             tick_c
);

  assign tick_c = (count == CNT_W'(CLKS_PER_BIT - 1));

  // Wrap on each bit boundary; clear holds the counter at zero between frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a valid/ready stream; frames are start + data (LSB first)
// + optional parity + stop bits. Parity is built in when UART_TX_PARITY_EN is defined.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_tx_stream_if.slave    s_if,
  output logic               tx,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [UART_STATE_W-1:0] ST_IDLE   = UART_STATE_W'(IDLE);
  localparam logic [UART_STATE_W-1:0] ST_START  = UART_STATE_W'(START);
  localparam logic [UART_STATE_W-1:0] ST_DATA   = UART_STATE_W'(DATA);
  localparam logic [UART_STATE_W-1:0] ST_STOP   = UART_STATE_W'(STOP);
`ifdef UART_TX_PARITY_EN
  localparam logic [UART_STATE_W-1:0] ST_PARITY = UART_STATE_W'(PARITY);
`endif

  // Reject parameter sets outside the supported frame formats at elaboration.
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_stream: unsupported parameter combination");
  end

  logic [UART_STATE_W-1:0] state_q, state_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    ready_q, ready_d;
  logic                    tx_d, busy_d;
  logic                    accept_c;
  logic                    baud_clear_c;
  logic [CNT_W-1:0]        baud_cnt;
  logic                    tick_c;
`ifdef UART_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  assign s_if.tx_ready = ready_q;
  assign baud_clear_c  = (state_q == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (baud_clear_c),
    .count   (baud_cnt),
    .tick_c  (tick_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    tx_d     = 1'b1;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    accept_c = s_if.tx_valid & ready_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_START: begin
        if (tick_c) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_c) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = '0;
      end
    endcase

    // ready is only ever high in IDLE or the final stop cycle, so an accept always starts a frame.
    if (accept_c) begin
      state_d = ST_START;
      shift_d = s_if.tx_data;
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^s_if.tx_data) ^ 1'(PARITY_ODD);
`endif
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE) ||
              ((state_q == ST_STOP) && (bit_q == BIT_W'(STOP_BITS - 1)) &&
               (baud_cnt == CNT_W'(CLKS_PER_BIT - 2)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx      <= tx_d;
      busy    <= busy_d;
      ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: two instances (8N1/even and 7-bit, 2 stop, odd) checked every
// cycle against a frame-timeline model, plus directed literal expectations.
module tb_uart_tx_stream;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT  = 1;
  localparam int FLEN0 = 44;
  localparam int FLEN1 = 44;
`else
  localparam int PBIT  = 0;
  localparam int FLEN0 = 40;
  localparam int FLEN1 = 40;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] d0 = '0;
  logic [6:0] d1 = '0;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic       tx0, tx1, busy0, busy1;

  uart_tx_stream_if #(.DATA_BITS(8)) if0 ();
  uart_tx_stream_if #(.DATA_BITS(7)) if1 ();

  assign if0.tx_data  = d0;
  assign if0.tx_valid = v0;
  assign if1.tx_data  = d1;
  assign if1.tx_valid = v1;

  uart_tx_stream #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .STOP_BITS (1), .PARITY_ODD (0)
  ) dut0 (
    .clk (clk), .reset_n (reset_n), .s_if (if0.slave), .tx (tx0), .busy (busy0)
  );

  uart_tx_stream #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (7), .STOP_BITS (2), .PARITY_ODD (1)
  ) dut1 (
    .clk (clk), .reset_n (reset_n), .s_if (if1.slave), .tx (tx1), .busy (busy1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rem[2] = '{0, 0};
  int acc_cnt[2] = '{0, 0};
  logic [9:0] word[2];
  logic tx_log[0:127];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int flen(input int i);
    return (i == 0) ? FLEN0 : FLEN1;
  endfunction

  // Bit k of a frame: 0 start, 1..db data LSB first, optional parity, then stop ones.
  function automatic logic exp_bit(input int i, input logic [9:0] w, input int k);
    int   db;
    logic odd;
    db  = (i == 0) ? 8 : 7;
    odd = (i == 0) ? 1'b0 : 1'b1;
    if (k == 0) return 1'b0;
    if (k <= db) return w[4'(k - 1)];
    if (PBIT == 1 && k == db + 1) return (^w) ^ odd;
    return 1'b1;
  endfunction

  // Model: cycles remaining in the current frame; ready while at most one cycle is left.
  always @(posedge clk or negedge reset_n) begin
    logic rdy;
    logic val;
    if (!reset_n) begin
      rem[0] = 0;
      rem[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rdy = (rem[i] <= 1);
        val = (i == 0) ? v0 : v1;
        if (rem[i] > 0) rem[i] = rem[i] - 1;
        if (val && rdy) begin
          rem[i]  = flen(i);
          word[i] = (i == 0) ? 10'(d0) : 10'(d1);
          acc_cnt[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic etx;
    for (int i = 0; i < 2; i++) begin
      if (rem[i] == 0) etx = 1'b1;
      else etx = exp_bit(i, word[i], (flen(i) - rem[i]) / CPB);
      check($sformatf("tx%0d", i), int'((i == 0) ? tx0 : tx1), int'(etx));
      check($sformatf("busy%0d", i), int'((i == 0) ? busy0 : busy1), int'(rem[i] > 0));
      check($sformatf("ready%0d", i), int'((i == 0) ? if0.tx_ready : if1.tx_ready),
            int'(rem[i] <= 1));
    end
  end

  task automatic send(input int i, input logic [7:0] b);
    int start;
    int n;
    start = acc_cnt[i];
    n = 0;
    if (i == 0) begin d0 = b; v0 = 1'b1; end
    else begin d1 = b[6:0]; v1 = 1'b1; end
    while (acc_cnt[i] == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", int'(acc_cnt[i] != start), 1);
    if (i == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic capture(input int i, input int len, output int busy_n);
    busy_n = 0;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      tx_log[c] = (i == 0) ? tx0 : tx1;
      if ((i == 0) ? busy0 : busy1) busy_n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rem[0] != 0 || rem[1] != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", int'(rem[0] == 0 && rem[1] == 0), 1);
  endtask

  initial begin
    int busy_n;
    int n;
    int ones;
    logic [10:0] exp4b;
`ifdef UART_TX_PARITY_EN
    exp4b = 11'b10010010110;
`else
    exp4b = 11'b01010010110;
`endif

    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx0), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_ready", int'(if0.tx_ready), 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x4B
    send(0, 8'h4B);
    capture(0, FLEN0, busy_n);
    check("latency_tx_low", int'(tx_log[0]), 0);
    for (int k = 0; k < 10 + PBIT; k++)
      check($sformatf("byte4b_bit%0d", k), int'(tx_log[k * CPB + 2]), int'(exp4b[k]));
    check("byte4b_busy_cycles", busy_n, FLEN0);
    @(negedge clk);
    check("byte4b_busy_end", int'(busy0), 0);

    // Back-to-back 0x55 then 0xA3 with valid held
    send(0, 8'h55);
    d0 = 8'hA3;
    v0 = 1'b1;
    n = 0;
    begin
      int start;
      start = acc_cnt[0];
      while (acc_cnt[0] == start && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    v0 = 1'b0;
    check("b2b_accept_gap", n, FLEN0);
    check("b2b_start_immediate", int'(tx0), 0);
    busy_n = 0;
    while (busy0 && busy_n < 200) begin
      busy_n++;
      @(negedge clk);
    end
`ifdef UART_TX_PARITY_EN
    check("b2b_span", n + busy_n, 88);
`else
    check("b2b_span", n + busy_n, 80);
`endif

    // 7 data bits, 2 stop bits, byte 0x7F followed directly by 0x00
    drain();
    send(1, 8'h7F);
    d1 = 7'h00;
    v1 = 1'b1;
    capture(1, FLEN1 + 1, busy_n);
    v1 = 1'b0;
    check("b7f_start", int'(tx_log[2]), 0);
    ones = 0;
    for (int c = 4; c < 32; c++) ones += int'(tx_log[c]);
    check("b7f_data_ones", ones, 28);
    ones = 0;
    for (int c = (8 + PBIT) * CPB; c < FLEN1; c++) ones += int'(tx_log[c]);
    check("b7f_stop_high", ones, 8);
    check("b7f_next_start", int'(tx_log[FLEN1]), 0);
    drain();

`ifdef UART_TX_PARITY_EN
    // Parity of 0x07: even -> 1, odd -> 0
    send(0, 8'h07);
    capture(0, FLEN0, busy_n);
    check("par_even_bit", int'(tx_log[9 * CPB + 2]), 1);
    check("par_frame_len", busy_n, 44);
    drain();
    send(1, 8'h07);
    capture(1, FLEN1, busy_n);
    check("par_odd_bit", int'(tx_log[8 * CPB + 2]), 0);
    drain();
`endif

    // Reset in the middle of the data bits
    @(negedge clk);
    send(0, 8'hE1);
    repeat (15) @(negedge clk);
    check("pre_rst_tx", int'(tx0), 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx0), 1);
    check("midrst_ready", int'(if0.tx_ready), 1);
    check("midrst_busy", int'(busy0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(0, 8'hC3);
    capture(0, FLEN0, busy_n);
    check("post_rst_bit1", int'(tx_log[1 * CPB + 2]), 1);
    check("post_rst_bit3", int'(tx_log[3 * CPB + 2]), 0);
    check("post_rst_frame", busy_n, FLEN0);
    drain();

    // Random valid toggling with data changing every cycle, including mid-frame
    for (int c = 0; c < 3000; c++) begin
      v0 = ($urandom_range(0, 3) != 0);
      d0 = 8'($urandom);
      v1 = ($urandom_range(0, 1) != 0);
      d1 = 7'($urandom);
      @(negedge clk);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    drain();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
